// File: rtl/div_pkg.sv
// Shared types and defaults for the serial restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  localparam int DIV_N_DEFAULT = 32;

endpackage : div_pkg

// File: rtl/div_step.sv
// One unsigned restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference when it does not borrow.
module div_step
  import div_pkg::*;
#(
  parameter int N = DIV_N_DEFAULT
) (
  input  logic [N:0]   r,
  input  logic         q_msb,
  input  logic [N-1:0] divisor,
  output logic [N:0]   r_next,
  output logic         q_bit
);

  localparam int unsigned RW = N + 1;

  logic [N:0] r_shift;
  logic [N:0] d_ext;
  logic [N:0] diff;

  // Compare and subtract are N+1 bits so the bit shifted out of r[N-1] is kept.
  always_comb begin
    r_shift = RW'({r, q_msb});
    d_ext   = {1'b0, divisor};
    diff    = r_shift - d_ext;
    q_bit   = (r_shift >= d_ext);
    r_next  = q_bit ? diff : r_shift;
  end

endmodule : div_step

// File: rtl/div_serial.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/end_div handshake matching mult_serial.
module div_serial
  import div_pkg::*;
#(
  parameter int N = DIV_N_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         end_div,
  output logic [N-1:0] quociente,
  output logic [N-1:0] resto,
  output logic         div_by_zero
);

  localparam int unsigned CW = $clog2(N);

  div_state_t    state;
  div_state_t    state_next;
  logic [CW-1:0] count;
  logic          primed;
  logic [N-1:0]  q;
  logic [N:0]    r;
  logic [N-1:0]  divisor;

  logic          accept;
  logic          do_step;
  logic          last;
  logic [N:0]    r_next;
  logic          q_bit;

  div_step #(.N(N)) u_step (
    .r       (r),
    .q_msb   (q[N-1]),
    .divisor (divisor),
    .r_next  (r_next),
    .q_bit   (q_bit)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and datapath strobes; the first BUSY cycle only arms the step engine,
  // which places completion N+1 edges after the accepting edge.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    do_step    = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (primed) begin
          do_step = 1'b1;
          if (count == CW'(N - 1)) begin
            last       = 1'b1;
            state_next = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Working registers and result registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      primed      <= 1'b0;
      q           <= '0;
      r           <= '0;
      divisor     <= '0;
      end_div     <= 1'b0;
      quociente   <= '0;
      resto       <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        q       <= A;
        divisor <= B;
        r       <= '0;
        count   <= '0;
        primed  <= 1'b0;
        end_div <= 1'b0;
      end else if (state == BUSY && !primed) begin
        primed <= 1'b1;
      end else if (do_step) begin
        q     <= {q[N-2:0], q_bit};
        r     <= r_next;
        count <= count + 1'b1;
        if (last) begin
          quociente   <= {q[N-2:0], q_bit};
          resto       <= r_next[N-1:0];
          div_by_zero <= (divisor == '0);
          end_div     <= 1'b1;
        end
      end
    end
  end

endmodule : div_serial
